alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 clock  input  1  system clock; the datapath is stateless and does not use it.
REQ-002 reset  input  1  synchronous, active-high reset; the datapath is stateless and does not use it.
REQ-003 io_dw  input  1  operand width: 1 = 64-bit (DW_64), 0 = 32-bit word op (DW_32).
REQ-004 io_fn  input  4  function code, listed in REQ-008.
REQ-005 io_in1  input  64  operand 1.
REQ-006 io_in2  input  64  operand 2.
REQ-007 Outputs: io_out (64) is the result; io_adder_out (64) is the raw adder result; io_cmp_out (1) is the compare result.

Function
REQ-008 Function codes: ADD=0, SL=1, SEQ=2, SNE=3, XOR=4, SR=5, OR=6, AND=7, SUB=10, SRA=11, SLT=12, SGE=13, SLTU=14, SGEU=15; codes 8 and 9 are reserved.
REQ-009 The block is purely combinational with zero-cycle latency; all outputs follow the inputs in the same cycle.
REQ-010 Subtract select: is_sub = fn[3]; in2_inv = is_sub ? ~in2 : in2.
REQ-011 io_adder_out = in1 + in2_inv + is_sub, mod 2^64, for every fn and dw; it is never truncated or sign-extended.
REQ-012 xor_v = in1 ^ in2_inv.
REQ-013 slt = adder_out[63] when in1[63] == in2[63]; otherwise slt = fn[1] ? in2[63] : in1[63] (fn[1] selects unsigned compare).
REQ-014 io_cmp_out = fn[0] XOR (fn[3] ? slt : (xor_v == 0)), defined for every code (fn[0] inverts the result).
REQ-015 Shift amount = {in2[5] AND dw, in2[4:0]}, so a 32-bit op masks bit 5.
REQ-016 Shift source: in1 when dw = 1; otherwise {32 copies of (is_sub AND in1[31]), in1[31:0]}.
REQ-017 SR: logical right shift of the shift source; SRA: arithmetic right shift; SL: left shift of the shift source (bit-reverse, right-shift, bit-reverse is an acceptable implementation).
REQ-018 Logic ops: XOR = in1^in2; OR = in1|in2; AND = in1&in2.
REQ-019 SEQ, SNE and SLT..SGEU: io_out = zero-extended io_cmp_out.
REQ-020 ADD and SUB: io_out = adder_out.
REQ-021 Reserved codes 8 and 9: io_out = 0.
REQ-022 When dw = 0, io_out = sign-extension of result[31:0] for every fn; when dw = 1, io_out = the full 64-bit result.
REQ-023 Outputs are free of X whenever inputs are free of X.

Reset
REQ-024 The block holds no state, so reset has no effect on outputs; outputs are valid in the reset cycle and in every following cycle.

Structure
REQ-025 Package alu_pkg holds the FN_* codes (4-bit localparams) and DW_32/DW_64; callers decoding micro-ops import the same package.
REQ-026 There is a single flat module with no sub-modules; the shifter is inline logic.

Verification
REQ-027 ADD, dw=1, in1=0xFFFFFFFFFFFFFFFF, in2=1 -> io_out=0 and io_adder_out=0; ADD, dw=0, in1=0x7FFFFFFF, in2=1 -> io_out=0xFFFFFFFF80000000.
REQ-028 SUB, dw=0, in1=0, in2=1 -> io_out=0xFFFFFFFFFFFFFFFF and io_adder_out=0xFFFFFFFFFFFFFFFF.
REQ-029 dw=0, in1=0x80000000, in2=4 -> SRA: io_out=0xFFFFFFFFF8000000; SR: io_out=0x08000000. dw=0 SL, in1=1, in2=0x3F -> io_out=0xFFFFFFFF80000000. dw=1 SL, in1=1, in2=0x3F -> io_out=0x8000000000000000.
REQ-030 in1=0xFFFFFFFFFFFFFFFF, in2=1 -> SLT: cmp_out=1, io_out=1; SLTU: cmp_out=0; SGE: cmp_out=0; SGEU: cmp_out=1.
REQ-031 in1=in2=0x1234 -> SEQ: cmp_out=1; SNE: cmp_out=0. in1=0x1234, in2=0x1235 -> SEQ: cmp_out=0.
REQ-032 dw=1, in1=0xF0, in2=0xFF -> XOR: io_out=0x0F; OR: 0xFF; AND: 0xF0. Reserved fn=8 -> io_out=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU function codes and operand-width encodings; micro-op decoders
// import this package too so both sides agree on the encoding.
package alu_pkg;
  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SL   = 4'd1;
  localparam logic [3:0] FN_SEQ  = 4'd2;
  localparam logic [3:0] FN_SNE  = 4'd3;
  localparam logic [3:0] FN_XOR  = 4'd4;
  localparam logic [3:0] FN_SR   = 4'd5;
  localparam logic [3:0] FN_OR   = 4'd6;
  localparam logic [3:0] FN_AND  = 4'd7;
  localparam logic [3:0] FN_SUB  = 4'd10;
  localparam logic [3:0] FN_SRA  = 4'd11;
  localparam logic [3:0] FN_SLT  = 4'd12;
  localparam logic [3:0] FN_SGE  = 4'd13;
  localparam logic [3:0] FN_SLTU = 4'd14;
  localparam logic [3:0] FN_SGEU = 4'd15;

  localparam logic DW_32 = 1'b0;
  localparam logic DW_64 = 1'b1;

  localparam int XLEN = 64;
endpackage

// File: rtl/alu.sv
// Combinational integer ALU: add/sub, compares, shifts and logic ops with
// optional 32-bit word mode (results sign-extended from bit 31).
module alu
  import alu_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            io_dw,
  input  logic [3:0]      io_fn,
  input  logic [XLEN-1:0] io_in1,
  input  logic [XLEN-1:0] io_in2,
  output logic [XLEN-1:0] io_out,
  output logic [XLEN-1:0] io_adder_out,
  output logic            io_cmp_out
);
  // Stateless datapath: clock and reset are part of the interface only.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clock, reset};

  logic            is_sub;
  logic [XLEN-1:0] in2_inv;
  logic [XLEN-1:0] xor_v;
  logic            slt;

  assign is_sub       = io_fn[3];
  assign in2_inv      = is_sub ? ~io_in2 : io_in2;
  assign io_adder_out = io_in1 + in2_inv + {{(XLEN-1){1'b0}}, is_sub};
  assign xor_v        = io_in1 ^ in2_inv;

  // Signs equal: difference sign decides; otherwise the operand signs decide.
  assign slt = (io_in1[XLEN-1] == io_in2[XLEN-1]) ? io_adder_out[XLEN-1]
             : (io_fn[1] ? io_in2[XLEN-1] : io_in1[XLEN-1]);
  assign io_cmp_out = io_fn[0] ^ (io_fn[3] ? slt : (xor_v == '0));

  logic [5:0]      shamt;
  logic [XLEN-1:0] sh_src;
  logic [XLEN:0]   sh_ext;
  logic [XLEN-1:0] shr;
  logic [XLEN-1:0] shl;

  assign shamt  = {io_in2[5] & io_dw, io_in2[4:0]};
  assign sh_src = io_dw ? io_in1 : {{32{is_sub & io_in1[31]}}, io_in1[31:0]};
  // Extra top bit carries the fill value so one arithmetic shift covers SR and SRA.
  assign sh_ext = $signed({is_sub & sh_src[XLEN-1], sh_src}) >>> shamt;
  assign shr    = sh_ext[XLEN-1:0];
  assign shl    = sh_src << shamt;

  logic [XLEN-1:0] res;

  always_comb begin
    res = '0;
    case (io_fn)
      FN_ADD, FN_SUB: res = io_adder_out;
      FN_SL:          res = shl;
      FN_SR, FN_SRA:  res = shr;
      FN_XOR:         res = io_in1 ^ io_in2;
      FN_OR:          res = io_in1 | io_in2;
      FN_AND:         res = io_in1 & io_in2;
      FN_SEQ, FN_SNE, FN_SLT, FN_SGE, FN_SLTU, FN_SGEU:
                      res = {{(XLEN-1){1'b0}}, io_cmp_out};
      default:        res = '0;
    endcase
  end

  assign io_out = io_dw ? res : {{32{res[31]}}, res[31:0]};
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu with hand-computed expected results.
module tb_alu;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_dw;
  logic [3:0]  io_fn;
  logic [63:0] io_in1, io_in2;
  logic [63:0] io_out, io_adder_out;
  logic        io_cmp_out;

  int n_vec = 0;
  int n_err = 0;

  alu dut (
    .clock(clock), .reset(reset), .io_dw(io_dw), .io_fn(io_fn),
    .io_in1(io_in1), .io_in2(io_in2), .io_out(io_out),
    .io_adder_out(io_adder_out), .io_cmp_out(io_cmp_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dw, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b);
    @(negedge clock);
    io_dw = dw; io_fn = fn; io_in1 = a; io_in2 = b;
    #1;
  endtask

  initial begin
    // Outputs must be valid while reset is asserted.
    drive(DW_64, FN_ADD, 64'd5, 64'd7);
    chk("rst_add_out", io_out, 64'd12);
    chk("rst_add_adder", io_adder_out, 64'd12);
    @(negedge clock);
    reset = 1'b0;

    drive(DW_64, FN_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("add64_wrap_out", io_out, 64'd0);
    chk("add64_wrap_adder", io_adder_out, 64'd0);
    drive(DW_32, FN_ADD, 64'h7FFF_FFFF, 64'd1);
    chk("add32_ovf_out", io_out, 64'hFFFF_FFFF_8000_0000);
    chk("add32_adder_full", io_adder_out, 64'h0000_0000_8000_0000);

    drive(DW_32, FN_SUB, 64'd0, 64'd1);
    chk("sub32_out", io_out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub32_adder", io_adder_out, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(DW_64, FN_SUB, 64'd10, 64'd3);
    chk("sub64_out", io_out, 64'd7);

    drive(DW_32, FN_SRA, 64'h8000_0000, 64'd4);
    chk("sra32", io_out, 64'hFFFF_FFFF_F800_0000);
    drive(DW_32, FN_SR, 64'h8000_0000, 64'd4);
    chk("sr32", io_out, 64'h0000_0000_0800_0000);
    drive(DW_32, FN_SR, 64'h8000_0000, 64'h24);
    chk("sr32_mask_b5", io_out, 64'h0000_0000_0800_0000);
    drive(DW_32, FN_SL, 64'd1, 64'h3F);
    chk("sl32", io_out, 64'hFFFF_FFFF_8000_0000);
    drive(DW_64, FN_SL, 64'd1, 64'h3F);
    chk("sl64", io_out, 64'h8000_0000_0000_0000);
    drive(DW_64, FN_SRA, 64'h8000_0000_0000_0000, 64'd4);
    chk("sra64", io_out, 64'hF800_0000_0000_0000);
    drive(DW_64, FN_SR, 64'h8000_0000_0000_0000, 64'd4);
    chk("sr64", io_out, 64'h0800_0000_0000_0000);

    drive(DW_64, FN_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("slt_cmp", {63'd0, io_cmp_out}, 64'd1);
    chk("slt_out", io_out, 64'd1);
    drive(DW_64, FN_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("sltu_cmp", {63'd0, io_cmp_out}, 64'd0);
    chk("sltu_out", io_out, 64'd0);
    drive(DW_64, FN_SGE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("sge_cmp", {63'd0, io_cmp_out}, 64'd0);
    drive(DW_64, FN_SGEU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("sgeu_cmp", {63'd0, io_cmp_out}, 64'd1);
    drive(DW_64, FN_SLT, 64'd3, 64'd9);
    chk("slt_same_sign", {63'd0, io_cmp_out}, 64'd1);

    drive(DW_64, FN_SEQ, 64'h1234, 64'h1234);
    chk("seq_eq_cmp", {63'd0, io_cmp_out}, 64'd1);
    chk("seq_eq_out", io_out, 64'd1);
    drive(DW_64, FN_SNE, 64'h1234, 64'h1234);
    chk("sne_eq_cmp", {63'd0, io_cmp_out}, 64'd0);
    drive(DW_64, FN_SEQ, 64'h1234, 64'h1235);
    chk("seq_ne_cmp", {63'd0, io_cmp_out}, 64'd0);

    drive(DW_64, FN_XOR, 64'hF0, 64'hFF);
    chk("xor", io_out, 64'h0F);
    drive(DW_64, FN_OR, 64'hF0, 64'hFF);
    chk("or", io_out, 64'hFF);
    drive(DW_64, FN_AND, 64'hF0, 64'hFF);
    chk("and", io_out, 64'hF0);
    drive(DW_32, FN_OR, 64'h8000_0000, 64'h0);
    chk("or32_sext", io_out, 64'hFFFF_FFFF_8000_0000);

    drive(DW_64, 4'd8, 64'hF0, 64'hFF);
    chk("rsv8_out", io_out, 64'd0);
    drive(DW_64, 4'd9, 64'd5, 64'd3);
    chk("rsv9_out", io_out, 64'd0);
    chk("rsv9_adder", io_adder_out, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
